// File: rtl/hdmi_i2c_pkg.sv
// hdmi_i2c_pkg: shared types and constants for the HDMI I2C transfer arbiter.
//   state_t      - arbiter FSM states
//   xfer_t       - 24-bit transfer word {slave addr, sub addr, data}
//   ADV7513_ADDR - 8-bit write address of the ADV7513 HDMI transmitter
package hdmi_i2c_pkg;
    typedef enum logic [2:0] {IDLE, ISSUE, BUSY, WAIT_END, RESP} state_t;
    typedef logic [23:0] xfer_t;
    localparam logic [7:0] ADV7513_ADDR = 8'h72;
endpackage

// File: rtl/i2c_arbiter_if.sv
// i2c_arbiter_if: requester and engine signals of the two-port I2C arbiter.
//   req[1:0], data0, data1   - per-port request level and transfer word
//   done[1:0], err[1:0]      - per-port completion pulse and failure flag
//   busy                     - arbiter owns the engine
//   eng_start, eng_data      - START and transfer word to the shared engine
//   eng_end, eng_ack         - engine END (low while running) and ACK (1 = NACK)
//   modport master: the arbiter; modport slave: requesters plus engine
interface i2c_arbiter_if;
    import hdmi_i2c_pkg::*;
    logic [1:0] req;
    xfer_t      data0;
    xfer_t      data1;
    logic [1:0] done;
    logic [1:0] err;
    logic       busy;
    logic       eng_start;
    xfer_t      eng_data;
    logic       eng_end;
    logic       eng_ack;
    modport master (
        input  req, data0, data1, eng_end, eng_ack,
        output done, err, busy, eng_start, eng_data
    );
    modport slave (
        output req, data0, data1, eng_end, eng_ack,
        input  done, err, busy, eng_start, eng_data
    );
endinterface

// File: rtl/i2c_rr_arb2.sv
// i2c_rr_arb2: two-way round-robin grant with its priority pointer.
//   iCLK, iRST_N - clock, asynchronous active-low reset
//   req[1:0]     - request levels
//   take         - grant is accepted this cycle; pointer moves past the winner
//   gnt[1:0]     - one-hot combinational grant (zero when no request)
module i2c_rr_arb2 (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] gnt
);
    // ptr = 1 gives port 1 priority on a conflict
    logic ptr;
    always_comb
        gnt = ptr ? (req[1] ? 2'b10 : {1'b0, req[0]})
                  : (req[0] ? 2'b01 : {req[1], 1'b0});
    always_ff @(posedge iCLK or negedge iRST_N)
        if (!iRST_N)
            ptr <= 1'b0;
        else if (take)
            ptr <= gnt[0];
endmodule

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: shares one I2C write engine between two requesters, with
// NACK retries and a per-phase timeout.
//   RETRIES      - re-attempts after NACK before reporting error (0..7)
//   TIMEOUT      - iCLK cycles allowed in ISSUE or BUSY before abort
//   iCLK, iRST_N - clock, asynchronous active-low reset
//   bus          - i2c_arbiter_if.master: requester and engine signals
module i2c_arbiter
    import hdmi_i2c_pkg::*;
#(
    parameter int RETRIES = 3,
    parameter int TIMEOUT = 1_000_000
) (
    input logic            iCLK,
    input logic            iRST_N,
    i2c_arbiter_if.master  bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state, state_n;
    logic [1:0]    gnt;
    logic          take;
    logic          port;
    logic          nack;
    logic          expired;
    logic [2:0]    retry_cnt;
    logic [TW-1:0] tmo_cnt;
    xfer_t         eng_data_q;

    assign take    = (state == IDLE) && |bus.req;
    assign expired = tmo_cnt == TW'(TIMEOUT);

    i2c_rr_arb2 u_arb (
        .iCLK  (iCLK),
        .iRST_N(iRST_N),
        .req   (bus.req),
        .take  (take),
        .gnt   (gnt)
    );

    always_ff @(posedge iCLK or negedge iRST_N)
        if (!iRST_N)
            state <= IDLE;
        else
            state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = take ? ISSUE : IDLE;
            ISSUE:    state_n = expired ? RESP : (!bus.eng_end ? BUSY : ISSUE);
            BUSY:     state_n = expired ? RESP : (bus.eng_end ? WAIT_END : BUSY);
            WAIT_END: state_n = (nack && retry_cnt < 3'(RETRIES)) ? ISSUE : RESP;
            RESP:     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // nack doubles as the error status: engine NACK, or forced on timeout
    always_ff @(posedge iCLK or negedge iRST_N)
        if (!iRST_N) begin
            eng_data_q <= '0;
            port       <= 1'b0;
            nack       <= 1'b0;
            retry_cnt  <= '0;
            tmo_cnt    <= '0;
        end else begin
            if (take) begin
                eng_data_q <= gnt[1] ? bus.data1 : bus.data0;
                port       <= gnt[1];
                retry_cnt  <= '0;
            end
            if (state == WAIT_END && state_n == ISSUE)
                retry_cnt <= retry_cnt + 1'b1;
            if ((state == ISSUE || state == BUSY) && expired)
                nack <= 1'b1;
            else if (state == BUSY && bus.eng_end)
                nack <= bus.eng_ack;
            // restarts on every state entry, so each phase gets a full budget
            tmo_cnt <= (state_n != state || !(state == ISSUE || state == BUSY))
                       ? '0 : tmo_cnt + 1'b1;
        end

    always_comb begin
        bus.eng_start = state == ISSUE;
        bus.eng_data  = eng_data_q;
        bus.busy      = state != IDLE;
        bus.done      = (state == RESP) ? (port ? 2'b10 : 2'b01) : 2'b00;
        bus.err       = (state == RESP && nack) ? (port ? 2'b10 : 2'b01) : 2'b00;
    end
endmodule
